dvs_event_scheduler: RTL

// - Buffers and paces decoded DVS events between the AER receiver and the RAVENS spike-input port.
// - Receiver side: one-cycle event pulses, no backpressure. Events are queued in a FIFO.
// - RAVENS side: events issue one at a time on a valid/ready handshake, with a minimum gap between spikes.
// - Also provides enable/flush control and drop statistics for the host.

---
 rtl/dvs_event_scheduler.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dvs_event_scheduler.sv
// DVS event scheduler: queues receiver events in a FIFO and issues them to the
// RAVENS spike port one at a time over valid/ready, with a minimum idle gap after each spike.
package dvs_ravens_pkg;
  localparam int DVS_X_ADDR_BITS   = 9;
  localparam int DVS_Y_ADDR_BITS   = 9;
  localparam int TIMESTAMP_US_BITS = 32;

  typedef struct packed {
    logic [DVS_X_ADDR_BITS-1:0]   x;
    logic [DVS_Y_ADDR_BITS-1:0]   y;
    logic [TIMESTAMP_US_BITS-1:0] timestamp;
    logic                         polarity;
  } dvs_evt_t;
endpackage

module dvs_event_scheduler
  import dvs_ravens_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int MIN_GAP_CYCLES = 4,
  parameter int OVF_CNT_BITS   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            flush,
  input  logic                            in_valid,
  input  logic [DVS_X_ADDR_BITS-1:0]      in_x,
  input  logic [DVS_Y_ADDR_BITS-1:0]      in_y,
  input  logic [TIMESTAMP_US_BITS-1:0]    in_timestamp,
  input  logic                            in_polarity,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DVS_X_ADDR_BITS-1:0]      out_x,
  output logic [DVS_Y_ADDR_BITS-1:0]      out_y,
  output logic [TIMESTAMP_US_BITS-1:0]    out_timestamp,
  output logic                            out_polarity,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [OVF_CNT_BITS-1:0]         overflow_count,
  output logic                            busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (MIN_GAP_CYCLES < 1) ? 1 : $clog2(MIN_GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t        state;
  logic [GW-1:0] gap_cnt;
  logic [AW:0]   wr_ptr, rd_ptr;
  dvs_evt_t      mem [FIFO_DEPTH];
  dvs_evt_t      head, in_evt;
  logic          full, pop, push, drop;

  assign in_evt = '{x: in_x, y: in_y, timestamp: in_timestamp, polarity: in_polarity};
  assign head   = mem[rd_ptr[AW-1:0]];

  assign fifo_count = wr_ptr - rd_ptr;
  // Extra MSB separates full from empty when the indices coincide.
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop  = out_valid && out_ready && !flush;
  assign push = in_valid && enable && !flush && (!full || pop);
  assign drop = in_valid && enable && !flush && full && !pop;

  assign out_x         = head.x;
  assign out_y         = head.y;
  assign out_timestamp = head.timestamp;
  assign out_polarity  = head.polarity;
  assign busy          = (state != IDLE) || (fifo_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= in_evt;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_count <= '0;
    end else if (drop && (overflow_count != '1)) begin
      overflow_count <= overflow_count + 1'b1;
    end
  end

  // IDLE also looks at a same-cycle push so a lone event is offered on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      gap_cnt   <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((fifo_count != '0) || push) begin
            state     <= ISSUE;
            out_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (pop) begin
            if (MIN_GAP_CYCLES > 0) begin
              state     <= GAP;
              out_valid <= 1'b0;
              gap_cnt   <= GW'(MIN_GAP_CYCLES);
            end else if ((fifo_count > (AW+1)'(1)) || push) begin
              state     <= ISSUE;
              out_valid <= 1'b1;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_cnt <= GW'(1)) begin
            state   <= IDLE;
            gap_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          gap_cnt   <= '0;
        end
      endcase
    end
  end
endmodule
